mor1kx_wb_stage_mux: RTL and testbench

Parametrised register-file writeback stage for the cappuccino pipeline, successor to the fixed ALU/LSU/SPR/MUL writeback mux. It registers the selected single-cycle result (ALU, LSU load, mfspr) and tracks NUM_LATE multi-cycle units (mul, div, FPU, ...) through a wait state, stalling the pipeline until the selected late result is valid. It also provides the RF write strobe and address, flush handling, and an explicit fault-injection mask port in place of a hierarchical testbench reference.

---
 rtl/mor1kx_wb_stage_mux_pkg.sv | 18 +
 rtl/mor1kx_wb_stage_mux_late_sel.sv | 34 +++
 rtl/mor1kx_wb_stage_mux.sv | 93 +++++++++
 tb/tb_mor1kx_wb_stage_mux.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mor1kx_wb_stage_mux_pkg.sv
// mor1kx_wb_stage_mux_pkg: writeback state encodings and index-width helper
package mor1kx_wb_stage_mux_pkg;

    localparam logic [1:0] MOR1KX_WB_STATE_IDLE   = 2'd0;
    localparam logic [1:0] MOR1KX_WB_STATE_DIRECT = 2'd1;
    localparam logic [1:0] MOR1KX_WB_STATE_WAIT   = 2'd2;

    typedef enum logic [1:0] {
        WB_IDLE   = MOR1KX_WB_STATE_IDLE,
        WB_DIRECT = MOR1KX_WB_STATE_DIRECT,
        WB_WAIT   = MOR1KX_WB_STATE_WAIT
    } wb_state_e;

    function automatic int idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mor1kx_wb_stage_mux_late_sel.sv
// mor1kx_wb_late_sel: lowest-set-bit encoder on late selects plus indexed result/valid pick
module mor1kx_wb_late_sel
    import mor1kx_wb_stage_mux_pkg::*;
#(
    parameter int NUM_LATE = 2,
    parameter int W        = 32,
    parameter int IW       = idx_width(NUM_LATE)
) (
    input  logic [NUM_LATE-1:0]   sel_i,
    input  logic [IW-1:0]         idx_i,
    input  logic [NUM_LATE*W-1:0] result_i,
    input  logic [NUM_LATE-1:0]   valid_i,
    output logic                  any_o,
    output logic [IW-1:0]         idx_o,
    output logic [W-1:0]          result_o,
    output logic                  valid_o
);

    assign any_o = |sel_i;

    always_comb begin
        idx_o    = '0;
        result_o = '0;
        valid_o  = 1'b0;
        for (int k = NUM_LATE - 1; k >= 0; k--)
            if (sel_i[k]) idx_o = IW'(k);
        for (int k = 0; k < NUM_LATE; k++)
            if (idx_i == IW'(k)) begin
                result_o = result_i[k*W +: W];
                valid_o  = valid_i[k];
            end
    end

endmodule

// File: rtl/mor1kx_wb_stage_mux.sv
// mor1kx_wb_stage_mux: RF writeback stage; registers single-cycle results and
// waits on a selected multi-cycle unit, stalling upstream until it is valid.
module mor1kx_wb_stage_mux
    import mor1kx_wb_stage_mux_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int NUM_LATE             = 2,
    parameter int OPTION_FI            = 0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [OPTION_OPERAND_WIDTH-1:0]          alu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]          lsu_result_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]          spr_i,
    input  logic [NUM_LATE*OPTION_OPERAND_WIDTH-1:0] late_result_i,
    input  logic [NUM_LATE-1:0]                  late_valid_i,
    input  logic                                 ex_valid_i,
    input  logic                                 ex_rf_we_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0]      ex_rfd_adr_i,
    input  logic                                 op_lsu_load_i,
    input  logic                                 op_mfspr_i,
    input  logic [NUM_LATE-1:0]                  op_late_i,
    input  logic                                 flush_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]          fi_mask_i,
    output logic [OPTION_OPERAND_WIDTH-1:0]          rf_result_o,
    output logic                                 rf_wb_o,
    output logic [OPTION_RF_ADDR_WIDTH-1:0]      rf_wb_adr_o,
    output logic                                 wb_valid_o,
    output logic                                 wb_stall_o
);

    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int A  = OPTION_RF_ADDR_WIDTH;
    localparam int IW = idx_width(NUM_LATE);

    wb_state_e      state_q, state_d;
    logic [W-1:0]   res_q, res_d;
    logic           we_q, we_d;
    logic [A-1:0]   adr_q, adr_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           late_any, late_vld, in_wait, stall, capture;
    logic [IW-1:0]  late_idx;
    logic [W-1:0]   late_res, fi;

    mor1kx_wb_late_sel #(.NUM_LATE(NUM_LATE), .W(W), .IW(IW)) u_late_sel (
        .sel_i    (op_late_i),
        .idx_i    (idx_q),
        .result_i (late_result_i),
        .valid_i  (late_valid_i),
        .any_o    (late_any),
        .idx_o    (late_idx),
        .result_o (late_res),
        .valid_o  (late_vld)
    );

    assign fi      = OPTION_FI != 0 ? fi_mask_i : '0;
    assign in_wait = state_q == WB_WAIT;
    assign stall   = in_wait & ~late_vld;
    assign capture = ex_valid_i & ~stall & ~flush_i;

    always_comb begin
        state_d = flush_i ? WB_IDLE : capture ? (late_any ? WB_WAIT : WB_DIRECT) : stall ? WB_WAIT : WB_IDLE;
        res_d   = (capture & ~late_any) ? ((op_mfspr_i ? spr_i : op_lsu_load_i ? lsu_result_i : alu_result_i) ^ fi) : res_q;
        we_d    = capture ? ex_rf_we_i : we_q;
        adr_d   = capture ? ex_rfd_adr_i : adr_q;
        idx_d   = capture ? late_idx : idx_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WB_IDLE;
            res_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            idx_q   <= idx_d;
        end
    end

    // Reset masks the outputs immediately so an abandoned WAIT never writes.
    assign rf_result_o = rst ? '0 : in_wait ? (late_res ^ fi) : res_q;
    assign rf_wb_o     = ~rst & ((state_q == WB_DIRECT) ? we_q : (in_wait & we_q & late_vld & ~flush_i));
    assign rf_wb_adr_o = rst ? '0 : adr_q;
    assign wb_valid_o  = ~rst & (state_q != WB_IDLE);
    assign wb_stall_o  = ~rst & stall;

endmodule

// File: tb/tb_mor1kx_wb_stage_mux.sv
// tb_mor1kx_wb_stage_mux: table vectors, corner sequences and randomized model check
module tb_mor1kx_wb_stage_mux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ev, we, ld, mf, fl;
    logic [4:0]  adr;
    logic [1:0]  lt, lv;
    logic [31:0] alu, lsu, spr, mask;
    logic [63:0] late;

    logic [31:0] res, res0;
    logic        wb, val, st, wb0, val0, st0;
    logic [4:0]  wadr, wadr0;

    mor1kx_wb_stage_mux #(.OPTION_FI(1)) dut (
        .clk(clk), .rst(rst), .alu_result_i(alu), .lsu_result_i(lsu), .spr_i(spr),
        .late_result_i(late), .late_valid_i(lv), .ex_valid_i(ev), .ex_rf_we_i(we),
        .ex_rfd_adr_i(adr), .op_lsu_load_i(ld), .op_mfspr_i(mf), .op_late_i(lt),
        .flush_i(fl), .fi_mask_i(mask), .rf_result_o(res), .rf_wb_o(wb),
        .rf_wb_adr_o(wadr), .wb_valid_o(val), .wb_stall_o(st)
    );

    mor1kx_wb_stage_mux #(.OPTION_FI(0)) dut0 (
        .clk(clk), .rst(rst), .alu_result_i(alu), .lsu_result_i(lsu), .spr_i(spr),
        .late_result_i(late), .late_valid_i(lv), .ex_valid_i(ev), .ex_rf_we_i(we),
        .ex_rfd_adr_i(adr), .op_lsu_load_i(ld), .op_mfspr_i(mf), .op_late_i(lt),
        .flush_i(fl), .fi_mask_i(mask), .rf_result_o(res0), .rf_wb_o(wb0),
        .rf_wb_adr_o(wadr0), .wb_valid_o(val0), .wb_stall_o(st0)
    );

    typedef struct {
        bit          ev, we, ld, mf, fl;
        logic [4:0]  adr;
        logic [1:0]  lt, lv;
        logic [31:0] src, l0, l1;
        logic [31:0] xres;
        bit          xwb, xval, xst;
        logic [4:0]  xadr;
    } vec_t;

    vec_t tbl[21];
    int total = 0, bad = 0;

    function automatic vec_t mk(bit ev_, bit we_, logic [4:0] adr_, bit ld_, bit mf_, logic [1:0] lt_,
                                bit fl_, logic [1:0] lv_, logic [31:0] src_, logic [31:0] l0_, logic [31:0] l1_,
                                logic [31:0] xres_, bit xwb_, bit xval_, bit xst_, logic [4:0] xadr_);
        vec_t v;
        v.ev = ev_; v.we = we_; v.adr = adr_; v.ld = ld_; v.mf = mf_; v.lt = lt_; v.fl = fl_; v.lv = lv_;
        v.src = src_; v.l0 = l0_; v.l1 = l1_;
        v.xres = xres_; v.xwb = xwb_; v.xval = xval_; v.xst = xst_; v.xadr = xadr_;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] xres, input bit xwb, input bit xval,
                           input bit xst, input logic [4:0] xadr);
        chk({tag, " result"}, res, xres);
        chk({tag, " wb"}, 32'(wb), 32'(xwb));
        chk({tag, " adr"}, 32'(wadr), 32'(xadr));
        chk({tag, " valid"}, 32'(val), 32'(xval));
        chk({tag, " stall"}, 32'(st), 32'(xst));
    endtask

    task automatic idle_inputs();
        rst = 0; ev = 0; we = 0; adr = 0; ld = 0; mf = 0; lt = 0; fl = 0; lv = 0;
        alu = 0; lsu = 0; spr = 0; late = 0; mask = 0;
    endtask

    // reference model state: what the writeback stage is holding, abstractly
    bit          m_busy, m_late, m_we;
    int          m_ch;
    logic [4:0]  m_adr;
    logic [31:0] m_res;

    initial begin
        idle_inputs();
        rst = 1;
        tbl[0]  = mk(1,1,3, 0,0,2'b00,0,2'b00,32'h12345678,0,0,                32'h0,0,0,0,0);
        tbl[1]  = mk(0,0,0, 0,0,2'b00,0,2'b00,0,0,0,                           32'h12345678,1,1,0,3);
        tbl[2]  = mk(1,1,7, 0,0,2'b10,0,2'b00,0,0,0,                           32'h12345678,0,0,0,3);
        tbl[3]  = mk(1,1,9, 0,0,2'b00,0,2'b01,32'hBAD,32'h11111111,32'hDEADBEEF, 32'hDEADBEEF,0,1,1,7);
        tbl[4]  = mk(0,0,0, 0,0,2'b00,0,2'b00,0,0,32'hDEADBEEF,                32'hDEADBEEF,0,1,1,7);
        tbl[5]  = mk(0,0,0, 0,0,2'b00,0,2'b10,0,0,32'hDEADBEEF,                32'hDEADBEEF,1,1,0,7);
        tbl[6]  = mk(0,0,0, 0,0,2'b00,0,2'b00,0,0,0,                           32'h12345678,0,0,0,7);
        tbl[7]  = mk(1,1,4, 0,1,2'b11,0,2'b00,32'h5555AAAA,0,0,                32'h12345678,0,0,0,7);
        tbl[8]  = mk(0,0,0, 0,0,2'b00,0,2'b10,0,32'h0BADF00D,32'hCAFECAFE,     32'h0BADF00D,0,1,1,4);
        tbl[9]  = mk(1,1,5, 0,0,2'b00,0,2'b01,32'h42,32'h600DF00D,0,           32'h600DF00D,1,1,0,4);
        tbl[10] = mk(1,1,6, 0,0,2'b10,0,2'b00,0,0,0,                           32'h42,1,1,0,5);
        tbl[11] = mk(1,1,8, 0,0,2'b00,1,2'b00,32'h99,0,32'h77777777,           32'h77777777,0,1,1,6);
        tbl[12] = mk(0,0,0, 0,0,2'b00,0,2'b10,0,0,32'h77777777,                32'h42,0,0,0,6);
        tbl[13] = mk(1,1,8, 0,0,2'b00,1,2'b00,32'h99,0,0,                      32'h42,0,0,0,6);
        tbl[14] = mk(0,0,0, 0,0,2'b00,0,2'b00,0,0,0,                           32'h42,0,0,0,6);
        tbl[15] = mk(1,1,2, 0,0,2'b00,0,2'b00,32'h13,0,0,                      32'h42,0,0,0,6);
        tbl[16] = mk(1,1,10,1,0,2'b00,0,2'b00,32'h1,0,0,                       32'h13,1,1,0,2);
        tbl[17] = mk(1,1,11,1,1,2'b00,0,2'b00,32'h0000FFFF,0,0,                32'hFFFFFFFE,1,1,0,10);
        tbl[18] = mk(1,0,12,0,0,2'b00,0,2'b00,32'h21,0,0,                      32'h5A5AA5A5,1,1,0,11);
        tbl[19] = mk(0,0,0, 0,0,2'b00,0,2'b00,0,0,0,                           32'h21,0,1,0,12);
        tbl[20] = mk(0,0,0, 0,0,2'b00,0,2'b00,0,0,0,                           32'h21,0,0,0,12);

        repeat (2) @(negedge clk);
        #1 chk_all("reset", 32'h0, 0, 0, 0, 0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            idle_inputs();
            ev = tbl[i].ev; we = tbl[i].we; adr = tbl[i].adr; ld = tbl[i].ld; mf = tbl[i].mf;
            lt = tbl[i].lt; fl = tbl[i].fl; lv = tbl[i].lv;
            alu = tbl[i].src; lsu = ~tbl[i].src; spr = tbl[i].src ^ 32'h5A5A5A5A;
            late = {tbl[i].l1, tbl[i].l0};
            #1 chk_all($sformatf("row%0d", i), tbl[i].xres, tbl[i].xwb, tbl[i].xval, tbl[i].xst, tbl[i].xadr);
        end

        // fault-injection mask: only the OPTION_FI=1 instance applies it
        @(negedge clk);
        idle_inputs();
        ev = 1; we = 1; ld = 1; adr = 1; lsu = 32'hFFFFFFFE; mask = 32'h1;
        @(negedge clk);
        idle_inputs();
        ev = 1; we = 1; lt = 2'b01; adr = 2; mask = 32'h1;
        #1;
        chk("fi load", res, 32'hFFFFFFFF);
        chk("nofi load", res0, 32'hFFFFFFFE);
        @(negedge clk);
        idle_inputs();
        lv = 2'b01; late = 64'h10; mask = 32'hF0;
        #1;
        chk("fi late", res, 32'hE0);
        chk("nofi late", res0, 32'h10);
        chk("fi late wb", 32'(wb & wb0), 32'h1);

        // reset while waiting abandons the pending write
        @(negedge clk);
        idle_inputs();
        ev = 1; we = 1; lt = 2'b01; adr = 9;
        @(negedge clk);
        idle_inputs();
        #1 chk("wait stall", 32'(st), 32'h1);
        @(negedge clk);
        idle_inputs();
        rst = 1; lv = 2'b01; late = 64'hABCD;
        #1 chk_all("rst in wait", 32'h0, 0, 0, 0, 0);
        @(negedge clk);
        idle_inputs();
        ev = 1; we = 1; alu = 32'h101; adr = 1;
        #1 chk_all("post rst", 32'h0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            idle_inputs();
            ev = 1; we = 1; alu = 32'h101 + 32'(i); adr = 5'(1 + i);
            #1 chk_all($sformatf("b2b%0d", i), 32'h100 + 32'(i), 1, 1, 0, 5'(i));
        end
        @(negedge clk);
        idle_inputs();
        #1 chk_all("b2b4", 32'h104, 1, 1, 0, 4);

        // randomized run against the abstract model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] xres;
            bit          xwb, xval, xst, v, cap;
            @(negedge clk);
            rst  = (n == 0) || ($urandom_range(0, 99) == 0);
            ev   = $urandom_range(0, 3) != 0;
            we   = 1'($urandom);
            adr  = 5'($urandom);
            ld   = 1'($urandom);
            mf   = $urandom_range(0, 3) == 0;
            lt   = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
            fl   = $urandom_range(0, 15) == 0;
            lv   = 2'($urandom);
            alu  = $urandom; lsu = $urandom; spr = $urandom;
            late = {$urandom, $urandom};
            mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            v    = m_late ? lv[m_ch] : 1'b0;
            if (rst) begin
                xres = 0; xwb = 0; xval = 0; xst = 0;
            end else if (!m_busy) begin
                xres = m_res; xwb = 0; xval = 0; xst = 0;
            end else if (!m_late) begin
                xres = m_res; xwb = m_we; xval = 1; xst = 0;
            end else begin
                xres = late[m_ch*32 +: 32] ^ mask; xwb = m_we & v & !fl; xval = 1; xst = !v;
            end
            #1 chk_all($sformatf("rnd%0d", n), xres, xwb, xval, xst, rst ? 5'd0 : m_adr);
            cap = !rst && ev && !xst && !fl;
            if (rst) begin
                m_busy = 0; m_late = 0; m_we = 0; m_ch = 0; m_adr = 0; m_res = 0;
            end else if (fl) begin
                m_busy = 0;
            end else if (cap) begin
                m_busy = 1; m_we = we; m_adr = adr; m_late = lt != 0;
                if (lt != 0) m_ch = lt[0] ? 0 : 1;
                else m_res = (mf ? spr : ld ? lsu : alu) ^ mask;
            end else if (!(m_busy && m_late && !v)) begin
                m_busy = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
